// File: rtl/pipe_pkg.sv
// Shared types and bubble encodings for the generic pipeline stage register.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_e;

   // Field encodings of an architectural no-op as seen by the EX stage.
   localparam logic [7:0]  EXE_NOP_OP   = 8'h00;
   localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
   localparam logic [4:0]  NOPRegAddr   = 5'b00000;
   localparam logic        WriteDisable = 1'b0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;

   localparam int unsigned IF_ID_W = 64;
   localparam logic [IF_ID_W-1:0] IF_ID_NOP = {ZeroWord, ZeroWord};

   // {aluop, alusel, reg1, reg2, waddr, we}
   localparam int unsigned ID_EX_W = 8 + 3 + 32 + 32 + 5 + 1;
   localparam logic [ID_EX_W-1:0] ID_EX_NOP =
      {EXE_NOP_OP, EXE_RES_NOP, ZeroWord, ZeroWord, NOPRegAddr, WriteDisable};

   // {waddr, we, wdata}
   localparam int unsigned EX_MEM_W = 5 + 1 + 32;
   localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = {NOPRegAddr, WriteDisable, ZeroWord};
   localparam int unsigned MEM_WB_W = EX_MEM_W;
   localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = EX_MEM_NOP;

   function automatic logic [1:0] occ_of(pipe_state_e st);
      unique case (st)
         ST_ONE:  occ_of = 2'd1;
         ST_TWO:  occ_of = 2'd2;
         default: occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One payload slot: data plus valid flag, loadable, clearable back to the bubble value.
module pipe_slot #(
   parameter int unsigned         DATA_W  = 128,
   parameter logic [DATA_W-1:0]   NOP_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;

   // Clear wins over load so a flush always leaves a clean bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= NOP_VAL;
      end else if (clear) begin
         valid_q <= 1'b0;
         data_q  <= NOP_VAL;
      end else if (load) begin
         valid_q <= 1'b1;
         data_q  <= load_data;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush-to-NOP.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid variant with a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W  = 128,
   parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   pipe_state_e state_q, state_d;

   logic              in_fire, out_fire;
   logic              main_load, main_clear;
   logic [DATA_W-1:0] main_din;
   logic              main_valid;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_load, skid_clear;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;

   // skid_valid is a flop output and is high exactly in ST_TWO.
   assign in_ready  = ~skid_valid;
   assign occupancy = occ_of(state_q);
`else
   assign in_ready  = ~main_valid | out_ready;
   assign occupancy = {1'b0, main_valid};
`endif

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d    = state_q;
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_din   = in_data;
`ifdef PIPE_STAGE_SKID_EN
      skid_load  = 1'b0;
      skid_clear = 1'b0;
`endif
      if (flush_i) begin
         state_d    = ST_EMPTY;
         main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
         skid_clear = 1'b1;
`endif
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d   = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
               end else if (in_fire) begin
                  state_d   = ST_TWO;
                  skid_load = 1'b1;
`endif
               end else if (out_fire) begin
                  state_d    = ST_EMPTY;
                  main_clear = 1'b1;
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_TWO: begin
               if (out_fire) begin
                  state_d    = ST_ONE;
                  main_load  = 1'b1;
                  main_din   = skid_data;
                  skid_clear = 1'b1;
               end
            end
`endif
            default: begin
               state_d    = ST_EMPTY;
               main_clear = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
   end

   pipe_slot #(
      .DATA_W  (DATA_W),
      .NOP_VAL (NOP_VAL)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .clear     (main_clear),
      .load_data (main_din),
      .valid     (main_valid),
      .data      (out_data)
   );

`ifdef PIPE_STAGE_SKID_EN
   pipe_slot #(
      .DATA_W  (DATA_W),
      .NOP_VAL (NOP_VAL)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_data (in_data),
      .valid     (skid_valid),
      .data      (skid_data)
   );
`endif

   assign out_valid = main_valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector tables, corner sequences and a randomized
// run against a queue-based reference model. Follows PIPE_STAGE_SKID_EN like the RTL.
module tb_pipe_stage_reg;

   localparam int unsigned DW  = 16;
   localparam logic [DW-1:0] NOP = 16'hDEAD;
`ifdef PIPE_STAGE_SKID_EN
   localparam int unsigned CAP = 2;
`else
   localparam int unsigned CAP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush_i = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          orr;
      logic          fl;
      logic          e_ov;
      logic [DW-1:0] e_d;
      logic [1:0]    e_occ;
      logic          e_ir;
   } vec_t;

   vec_t          vecs[$];
   logic [DW-1:0] mq[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W  (DW),
      .NOP_VAL (NOP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   task automatic check_outs(input string tag, input logic ov, input logic [DW-1:0] d,
                             input logic [1:0] occ, input logic ir);
      check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
      check({tag, ".out_data"}, {16'b0, out_data}, {16'b0, d});
      check({tag, ".occupancy"}, {30'b0, occupancy}, {30'b0, occ});
      check({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, ir});
   endtask

   // Reference model: a FIFO of capacity CAP seen through a valid/ready window.
   function automatic logic model_ready(input logic orr);
`ifdef PIPE_STAGE_SKID_EN
      return mq.size() < 2;
`else
      return (mq.size() == 0) || orr;
`endif
   endfunction

   task automatic model_step(input logic iv, input logic [DW-1:0] d, input logic orr,
                             input logic fl);
      logic in_f, out_f;
      in_f  = iv && model_ready(orr);
      out_f = (mq.size() != 0) && orr;
      if (fl) mq.delete();
      else begin
         if (out_f) void'(mq.pop_front());
         if (in_f) mq.push_back(d);
      end
   endtask

   task automatic check_model(input string tag);
      logic [DW-1:0] ed;
      ed = (mq.size() != 0) ? mq[0] : NOP;
      check_outs(tag, mq.size() != 0, ed, 2'(mq.size()), model_ready(out_ready));
   endtask

   task automatic add(input logic iv, input logic [DW-1:0] d, input logic orr, input logic fl,
                      input logic ov, input logic [DW-1:0] ed, input logic [1:0] occ,
                      input logic ir);
      vecs.push_back('{iv: iv, d: d, orr: orr, fl: fl, e_ov: ov, e_d: ed, e_occ: occ, e_ir: ir});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      mq.delete();
   endtask

   initial begin
      // Streaming: one beat per cycle, then drain.
      for (int k = 0; k < 8; k++) add(1, DW'(k + 1), 1, 0, 1, DW'(k + 1), 2'd1, 1);
      add(0, 0, 1, 0, 0, NOP, 2'd0, 1);
`ifdef PIPE_STAGE_SKID_EN
      // Backpressure into the skid slot, then release in order.
      add(1, 16'h10, 0, 0, 1, 16'h10, 2'd1, 1);
      add(1, 16'h11, 0, 0, 1, 16'h10, 2'd2, 0);
      add(1, 16'h12, 0, 0, 1, 16'h10, 2'd2, 0);
      add(1, 16'h12, 1, 0, 1, 16'h11, 2'd1, 1);
      add(1, 16'h12, 1, 0, 1, 16'h12, 2'd1, 1);
      add(0, 16'h00, 1, 0, 0, NOP,    2'd0, 1);
      // Flush while full; the concurrently offered beat is dropped.
      add(1, 16'h20, 0, 0, 1, 16'h20, 2'd1, 1);
      add(1, 16'h21, 0, 0, 1, 16'h20, 2'd2, 0);
      add(1, 16'h99, 0, 1, 0, NOP,    2'd0, 1);
      add(0, 16'h00, 1, 0, 0, NOP,    2'd0, 1);
`else
      // Backpressure on the single slot, then a same-edge swap.
      add(1, 16'h10, 0, 0, 1, 16'h10, 2'd1, 0);
      add(1, 16'h11, 0, 0, 1, 16'h10, 2'd1, 0);
      add(1, 16'h11, 1, 0, 1, 16'h11, 2'd1, 1);
      add(0, 16'h00, 1, 0, 0, NOP,    2'd0, 1);
      // Flush with a live input handshake: beat discarded.
      add(1, 16'h20, 0, 0, 1, 16'h20, 2'd1, 0);
      add(1, 16'h99, 1, 1, 0, NOP,    2'd0, 1);
      add(0, 16'h00, 1, 0, 0, NOP,    2'd0, 1);
`endif

      // Reset held with a beat offered.
      rst = 1'b0; in_valid = 1'b1; in_data = 16'hA5;
      repeat (3) @(posedge clk);
      #1 check_outs("reset", 0, NOP, 2'd0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         in_valid = vecs[i].iv; in_data = vecs[i].d;
         out_ready = vecs[i].orr; flush_i = vecs[i].fl;
         @(posedge clk);
         #1 check_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_d, vecs[i].e_occ,
                       vecs[i].e_ir);
      end

      // in_ready vs out_ready without a clock edge.
      do_reset();
      in_valid = 1'b1; in_data = 16'h33; out_ready = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1 check("full_ready_registered", {31'b0, in_ready}, 32'd0);
`else
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("stall_ready_low", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1 check("stall_ready_comb", {31'b0, in_ready}, 32'd1);
`endif

      // Asynchronous reset between edges with one beat held.
      do_reset();
      in_valid = 1'b1; in_data = 16'h44; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("async_pre_valid", {31'b0, out_valid}, 32'd1);
      #2 rst = 1'b0;
      #1 check_outs("async_rst", 0, NOP, 2'd0, 1);
      @(negedge clk);
      rst = 1'b1;
      mq.delete();

      // Randomized traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = DW'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush_i   = ($urandom_range(0, 19) == 0);
         model_step(in_valid, in_data, out_ready, flush_i);
         @(posedge clk);
         #1 check_model($sformatf("rand%0d", c));
         if (mq.size() > CAP) check("model_cap", 32'(mq.size()), 32'(CAP));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
